// File: rtl/beat_sequencer_pkg.sv
// beat_sequencer_pkg: beat/state types, default parameters and beat transition helpers
package beat_sequencer_pkg;
  localparam int PHASES_DEF = 4;
  localparam int T3_PHASE_DEF = 2;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {BEAT_NONE, BEAT_W1, BEAT_W2, BEAT_W3} beat_e;
  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_e;
  function automatic beat_e next_beat(beat_e b, logic short_v, logic long_v);
    return b == BEAT_W1 ? (short_v ? BEAT_W1 : BEAT_W2) :
           b == BEAT_W2 ? (long_v ? BEAT_W3 : BEAT_W1) :
           b == BEAT_W3 ? BEAT_W1 : BEAT_NONE;
  endfunction
  function automatic logic ends_cycle(beat_e b, logic short_v, logic long_v);
    return (b == BEAT_W1 && short_v) || (b == BEAT_W2 && !long_v) || b == BEAT_W3;
  endfunction
endpackage

// File: rtl/beat_sequencer_if.sv
// beat_sequencer_if: console/controller controls in, beat and phase timing out
interface beat_sequencer_if
  import beat_sequencer_pkg::*;
#(
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic start_i;
  logic stop_i;
  logic step_mode_i;
  logic short_i;
  logic long_i;
  logic w1_o;
  logic w2_o;
  logic w3_o;
  logic [PHASES-1:0] t_o;
  logic t3_o;
  logic running_o;
  logic cycle_end_o;
  logic [CNT_W-1:0] mcycle_cnt_o;
  modport master (
    output start_i, stop_i, step_mode_i, short_i, long_i,
    input w1_o, w2_o, w3_o, t_o, t3_o, running_o, cycle_end_o, mcycle_cnt_o
  );
  modport slave (
    input start_i, stop_i, step_mode_i, short_i, long_i,
    output w1_o, w2_o, w3_o, t_o, t3_o, running_o, cycle_end_o, mcycle_cnt_o
  );
endinterface

// File: rtl/beat_sequencer_phase_ring.sv
// beat_sequencer_phase_ring: one-hot phase ring with clear, load-phase-0 and rotate
module beat_sequencer_phase_ring #(
  parameter int PHASES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  output logic [PHASES-1:0] t_o,
  output logic              last_o
);
  logic [PHASES-1:0] t_q, t_d;
  assign t_d = clear_i ? '0 :
               load_i  ? {{(PHASES-1){1'b0}}, 1'b1} :
                         {t_q[PHASES-2:0], t_q[PHASES-1]};
  always_ff @(posedge clk)
    t_q <= rst ? '0 : t_d;
  assign t_o = t_q;
  assign last_o = t_q[PHASES-1];
endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: machine-cycle beat (w1/w2/w3) and phase strobe generator for the hardwired controller
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int PHASES = PHASES_DEF,
  parameter int T3_PHASE = T3_PHASE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  beat_sequencer_if.slave bus
);
  seq_state_e state_q, state_d;
  beat_e beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cycle_end_q, cycle_end_d;
  logic [PHASES-1:0] t;
  logic ring_last, ring_clear, ring_load, last, ends, halt;
  beat_sequencer_phase_ring #(.PHASES(PHASES)) u_ring (
    .clk(clk),
    .rst(rst),
    .clear_i(ring_clear),
    .load_i(ring_load),
    .t_o(t),
    .last_o(ring_last)
  );
  assign last = state_q == SEQ_RUN && ring_last;
  assign ends = last && ends_cycle(beat_q, bus.short_i, bus.long_i);
  assign halt = last && (bus.stop_i || (bus.step_mode_i && ends));
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    ring_clear = 1'b0;
    ring_load = 1'b0;
    cycle_end_d = ends;
    cnt_d = cnt_q + CNT_W'(ends);
    if (state_q == SEQ_IDLE) begin
      state_d = bus.start_i ? SEQ_RUN : SEQ_IDLE;
      beat_d = bus.start_i ? BEAT_W1 : BEAT_NONE;
      ring_load = bus.start_i;
      ring_clear = !bus.start_i;
    end else if (halt) begin
      state_d = SEQ_IDLE;
      beat_d = BEAT_NONE;
      ring_clear = 1'b1;
    end else if (last) begin
      beat_d = next_beat(beat_q, bus.short_i, bus.long_i);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      beat_q <= BEAT_NONE;
      cnt_q <= '0;
      cycle_end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
      cycle_end_q <= cycle_end_d;
    end
  end
  assign bus.w1_o = beat_q == BEAT_W1;
  assign bus.w2_o = beat_q == BEAT_W2;
  assign bus.w3_o = beat_q == BEAT_W3;
  assign bus.t_o = t;
  assign bus.t3_o = t[T3_PHASE];
  assign bus.running_o = state_q == SEQ_RUN;
  assign bus.cycle_end_o = cycle_end_q;
  assign bus.mcycle_cnt_o = cnt_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed self-checking bench for beat_sequencer
module tb_beat_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  always #5 clk = ~clk;
  beat_sequencer_if #(.PHASES(4), .CNT_W(16)) bus ();
  beat_sequencer_if #(.PHASES(4), .CNT_W(2)) bus2 ();
  beat_sequencer #(.PHASES(4), .T3_PHASE(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  beat_sequencer #(.PHASES(4), .T3_PHASE(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [9:0] obs();
    return {bus.running_o, bus.w1_o, bus.w2_o, bus.w3_o, bus.cycle_end_o, bus.t3_o, bus.t_o};
  endfunction
  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic chkn(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  initial begin
    {bus.start_i, bus.stop_i, bus.step_mode_i, bus.short_i, bus.long_i} = '0;
    {bus2.start_i, bus2.stop_i, bus2.step_mode_i, bus2.short_i, bus2.long_i} = '0;
    tick(2);
    chk("reset_out", obs(), 10'b0);
    chkn("reset_cnt", bus.mcycle_cnt_o, 16'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_held", obs(), 10'b0);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    chk("w1_p0", obs(), 10'b1_100_0_0_0001);
    tick(2);
    chk("w1_p2_t3", obs(), 10'b1_100_0_1_0100);
    tick(2);
    chk("w2_p0", obs(), 10'b1_010_0_0_0001);
    tick(3);
    chk("w2_p3", obs(), 10'b1_010_0_0_1000);
    chkn("cnt_before_end", bus.mcycle_cnt_o, 16'd0);
    tick(1);
    chk("cycle_end_8", obs(), 10'b1_100_1_0_0001);
    chkn("cnt_1", bus.mcycle_cnt_o, 16'd1);
    tick(1);
    chk("cycle_end_pulse", obs(), 10'b1_100_0_0_0010);
    tick(15);
    chk("after_24", obs(), 10'b1_100_1_0_0001);
    chkn("cnt_3", bus.mcycle_cnt_o, 16'd3);
    tick(1);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    chk("start_in_run", obs(), 10'b1_100_0_1_0100);
    bus.short_i = 1'b1;
    tick(2);
    chk("short_end", obs(), 10'b1_100_1_0_0001);
    chkn("short_cnt4", bus.mcycle_cnt_o, 16'd4);
    tick(2);
    chk("short_mid", obs(), 10'b1_100_0_1_0100);
    tick(2);
    chkn("short_cnt5", bus.mcycle_cnt_o, 16'd5);
    bus.long_i = 1'b1;
    tick(4);
    chk("short_long_w1", obs(), 10'b1_100_1_0_0001);
    chkn("short_long_cnt6", bus.mcycle_cnt_o, 16'd6);
    bus.short_i = 1'b0;
    tick(4);
    chk("long_w2", obs(), 10'b1_010_0_0_0001);
    tick(4);
    chk("long_w3", obs(), 10'b1_001_0_0_0001);
    tick(4);
    chk("long_end", obs(), 10'b1_100_1_0_0001);
    chkn("long_cnt7", bus.mcycle_cnt_o, 16'd7);
    tick(7);
    chk("stop_w2_p3", obs(), 10'b1_010_0_0_1000);
    bus.stop_i = 1'b1;
    tick(1);
    bus.stop_i = 1'b0;
    chk("stop_idle", obs(), 10'b0);
    chkn("stop_cnt", bus.mcycle_cnt_o, 16'd7);
    tick(1);
    chk("stop_held", obs(), 10'b0);
    bus.start_i = 1'b1;
    bus.stop_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    chk("start_stop_idle", obs(), 10'b1_100_0_0_0001);
    tick(5);
    chk("w2_p1", obs(), 10'b1_010_0_0_0010);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_beat", obs(), 10'b0);
    chkn("rst_cnt", bus.mcycle_cnt_o, 16'd0);
    bus.step_mode_i = 1'b1;
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    tick(11);
    chk("step_w3_p3", obs(), 10'b1_001_0_0_1000);
    tick(1);
    chk("step_halt", obs(), 10'b0_000_1_0_0000);
    chkn("step_cnt1", bus.mcycle_cnt_o, 16'd1);
    tick(1);
    chk("step_idle", obs(), 10'b0);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    tick(12);
    chk("step2_halt", obs(), 10'b0_000_1_0_0000);
    chkn("step_cnt2", bus.mcycle_cnt_o, 16'd2);
    bus.step_mode_i = 1'b0;
    bus.long_i = 1'b0;
    bus2.short_i = 1'b1;
    bus2.start_i = 1'b1;
    tick(1);
    bus2.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(4);
      chkn($sformatf("wrap_cnt%0d", i), 16'(bus2.mcycle_cnt_o), 16'(exp2[i]));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
